// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - IMEM_* state encodings and the typed FSM state enum
//   - IMEM_NOP: instruction returned for a faulting fetch
//   - default word-address width and access latency
//   - imem_addr_bad(): misaligned / out-of-range check for a byte address
package cpu_pkg;

    localparam int unsigned IMEM_AW_DEFAULT      = 8;
    localparam int unsigned IMEM_LATENCY_DEFAULT = 2;

    localparam logic [1:0] IMEM_IDLE = 2'd0;
    localparam logic [1:0] IMEM_WAIT = 2'd1;
    localparam logic [1:0] IMEM_RESP = 2'd2;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = IMEM_IDLE,
        StWait = IMEM_WAIT,
        StResp = IMEM_RESP
    } imem_state_e;

    // A byte address faults when it is not word aligned or lies above 2**aw words.
    function automatic logic imem_addr_bad(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] hi;
        hi = addr >> (aw + 32'd2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch handshake between the PC stage (master) and the instruction memory (slave).
//   req   : fetch request, addr valid while high
//   addr  : byte address (PC value)
//   flush : abort the outstanding fetch
//   instr : fetched instruction, qualified by valid
//   valid : one-cycle response pulse
//   err   : response faulted (misaligned / out of range), qualified by valid
//   stall : PC must hold (pcWrite = ~stall)
interface imem_responder_if;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic        stall;

    modport master (output req, addr, flush, input instr, valid, err, stall);
    modport slave  (input req, addr, flush, output instr, valid, err, stall);
endinterface

// File: rtl/imem_array.sv
// 2**AW x 32 RAM: one synchronous write port, one registered read port.
//   clk_i, start_i     : clock, async active-low reset (clears only the read register)
//   we_i/waddr_i/wdata_i : write port, takes effect on the rising edge
//   re_i/raddr_i       : read enable and word address
//   rdata_o            : registered read data; same-edge write to the read word returns old data
module imem_array #(
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a PC fetch, returns the instruction LATENCY
// cycles later, stalling the PC meanwhile. Supports flush and a program-write port.
//   clk_i, start_i : clock, async active-low reset
//   bus            : imem_responder_if slave (req/addr/flush in, instr/valid/err/stall out)
//   prog_*_i       : program-port write (enable, word address, data), legal in any state
// Optional build macro IMEM_LASTHIT_EN: one-entry last-hit tag; a repeat fetch of that
// word completes in one cycle.
module imem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned AW      = IMEM_AW_DEFAULT,
    parameter int unsigned LATENCY = IMEM_LATENCY_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    start_i,
    imem_responder_if.slave         bus,
    input  logic                    prog_we_i,
    input  logic [AW-1:0]           prog_addr_i,
    input  logic [31:0]             prog_data_i
);

    localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    logic          accept;
    logic          hit;
    logic          re;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata;

    assign accept = (state_q == StIdle) && bus.req && !bus.flush;

`ifdef IMEM_LASTHIT_EN
    // The read register only loads on good fetches, so while the tag is valid it
    // still holds the tagged word's data and serves as the cached instruction.
    logic [AW-1:0] tag_q, tag_d;
    logic          tag_valid_q, tag_valid_d;

    assign hit = tag_valid_q && !imem_addr_bad(bus.addr, AW) && (bus.addr[AW+1:2] == tag_q);

    always_comb begin
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        if (re) begin
            tag_d       = raddr;
            tag_valid_d = 1'b1;
        end
        if (prog_we_i && (prog_addr_i == tag_d)) begin
            tag_valid_d = 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        valid_d = 1'b0;
        re      = 1'b0;
        raddr   = addr_q[AW+1:2];
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = bus.addr;
                    cnt_d  = LatM1;
                    if (hit) begin
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = StResp;
                    end else if (LATENCY == 1) begin
                        re      = !imem_addr_bad(bus.addr, AW);
                        raddr   = bus.addr[AW+1:2];
                        err_d   = imem_addr_bad(bus.addr, AW);
                        valid_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd1) begin
                    re      = !imem_addr_bad(addr_q, AW);
                    err_d   = imem_addr_bad(addr_q, AW);
                    valid_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
`ifdef IMEM_LASTHIT_EN
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
`ifdef IMEM_LASTHIT_EN
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
`endif
        end
    end

    imem_array #(
        .AW (AW)
    ) u_array (
        .clk_i   (clk_i),
        .start_i (start_i),
        .we_i    (prog_we_i),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign bus.valid = valid_q && !bus.flush;
    assign bus.err   = err_q;
    assign bus.instr = err_q ? IMEM_NOP : rdata;
    assign bus.stall = accept || (state_q == StWait);

endmodule
